// File: rtl/seq_det_n.sv
// seq_det_n: serial pattern detector on falling n_clk with fill/window flags;
// match counter and clr_cnt present only when SEQ_DET_CNT_EN is defined.
module seq_det_n #(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit OVERLAP = 1,
  parameter int CNT_W = 8
) (
  input  logic n_clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  input  logic clr_cnt,
  output logic s,
  output logic t,
  output logic [$clog2(PAT_LEN+1)-1:0] fill,
  output logic [CNT_W-1:0] cnt
);
  localparam int FW = $clog2(PAT_LEN+1);
  logic [PAT_LEN-1:0] win, win_n;
  logic [FW-1:0] fill_n, fill_q;
  logic hit;
  always_comb begin
    win_n = {win[PAT_LEN-2:0], a};
    fill_n = (fill == FW'(PAT_LEN)) ? fill : fill + FW'(1);
    hit = en && fill_n == FW'(PAT_LEN) && win_n == PATTERN;
    fill_q = !en ? fill : (hit && !OVERLAP) ? '0 : fill_n;
  end
  always_ff @(negedge n_clk) begin
    if (rst) begin
      win <= '0;
      fill <= '0;
      s <= 1'b0;
      t <= 1'b0;
    end else begin
      if (en) win <= win_n;
      fill <= fill_q;
      s <= hit;
      t <= fill_q == FW'(PAT_LEN);
    end
  end
`ifdef SEQ_DET_CNT_EN
  always_ff @(negedge n_clk) begin
    if (rst || clr_cnt) cnt <= '0;
    else if (hit && !(&cnt)) cnt <= cnt + CNT_W'(1);
  end
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign cnt = '0;
`endif
endmodule

// File: tb/tb_seq_det_n.sv
// tb_seq_det_n: scoreboard bench over three seq_det_n variants (overlap, non-overlap, 2-bit counter).
module tb_seq_det_n;
  logic n_clk = 1'b0, rst = 1'b0, en = 1'b0, a = 1'b0, clr_cnt = 1'b0;
  logic [2:0] s, t;
  logic [2:0][2:0] fill;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [2:0][7:0] cnt_a;
  assign cnt_a[0] = cnt0;
  assign cnt_a[1] = cnt1;
  assign cnt_a[2] = {6'b0, cnt2};

  seq_det_n u0 (.n_clk(n_clk), .rst(rst), .en(en), .a(a), .clr_cnt(clr_cnt),
                .s(s[0]), .t(t[0]), .fill(fill[0]), .cnt(cnt0));
  seq_det_n #(.OVERLAP(0)) u1 (.n_clk(n_clk), .rst(rst), .en(en), .a(a), .clr_cnt(clr_cnt),
                .s(s[1]), .t(t[1]), .fill(fill[1]), .cnt(cnt1));
  seq_det_n #(.CNT_W(2)) u2 (.n_clk(n_clk), .rst(rst), .en(en), .a(a), .clr_cnt(clr_cnt),
                .s(s[2]), .t(t[2]), .fill(fill[2]), .cnt(cnt2));

  always #5 n_clk = ~n_clk;

  typedef struct packed {
    logic [2:0] s;
    logic [2:0] t;
    logic [2:0][2:0] fill;
    logic [2:0][7:0] cnt;
  } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0;
  int pulses[3] = '{0, 0, 0};

  // Reference keeps the raw bit history since the last reset/consumed match.
  bit h[3][1024];
  int hl[3] = '{0, 0, 0};
  int mc[3] = '{0, 0, 0};
  bit ov[3] = '{1'b1, 1'b0, 1'b1};
  int cmax[3] = '{255, 255, 3};

  task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] at %0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge n_clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      for (int i = 0; i < 3; i++) begin
        chk("s", i, {7'b0, s[i]}, {7'b0, e.s[i]});
        chk("t", i, {7'b0, t[i]}, {7'b0, e.t[i]});
        chk("fill", i, {5'b0, fill[i]}, {5'b0, e.fill[i]});
        chk("cnt", i, cnt_a[i], e.cnt[i]);
        if (s[i] === 1'b1) pulses[i]++;
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic x, input logic c);
    exp_t ex;
    bit m;
    @(posedge n_clk);
    rst = r; en = e; a = x; clr_cnt = c;
    for (int i = 0; i < 3; i++) begin
      m = 1'b0;
      if (r) begin
        hl[i] = 0;
        mc[i] = 0;
      end else begin
        if (e) begin
          h[i][hl[i]] = x;
          hl[i]++;
          m = hl[i] >= 4 && h[i][hl[i]-4] && !h[i][hl[i]-3] && h[i][hl[i]-2] && h[i][hl[i]-1];
          if (m && !ov[i]) hl[i] = 0;
        end
`ifdef SEQ_DET_CNT_EN
        if (c) mc[i] = 0;
        else if (m && mc[i] < cmax[i]) mc[i]++;
`endif
      end
      ex.s[i] = m;
      ex.fill[i] = hl[i] > 4 ? 3'd4 : 3'(hl[i]);
      ex.t[i] = hl[i] >= 4;
      ex.cnt[i] = 8'(mc[i]);
    end
    q.push_back(ex);
  endtask

  task automatic bits(input logic [15:0] v, input int n, input logic clr_last);
    for (int k = n - 1; k >= 0; k--) step(1'b0, 1'b1, v[k], clr_last && k == 0);
  endtask

  task automatic drain(input string nm, input int p0, input int p1, input int p2);
    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge n_clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d expectations left, expected 0", nm, q.size());
      q.delete();
    end
    chk({nm, "_pulses"}, 0, 8'(pulses[0]), 8'(p0));
    chk({nm, "_pulses"}, 1, 8'(pulses[1]), 8'(p1));
    chk({nm, "_pulses"}, 2, 8'(pulses[2]), 8'(p2));
    pulses = '{0, 0, 0};
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    drain("reset", 0, 0, 0);

    bits(16'b1011, 4, 1'b0);
    idle(2);
    drain("basic", 1, 1, 1);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    bits(16'b1011011, 7, 1'b0);
    idle(2);
    drain("overlap", 2, 1, 2);
    chk("overlap_fill_end", 1, {5'b0, fill[1]}, 8'd3);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    bits(16'b10, 2, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("gate_fill_held", 0, {5'b0, fill[0]}, 8'd2);
    bits(16'b11, 2, 1'b0);
    idle(1);
    drain("gating", 1, 1, 1);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) bits(16'b1011, 4, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    bits(16'b1011, 4, 1'b0);
    bits(16'b1011, 4, 1'b1);
    idle(2);
    drain("satclr", 7, 7, 7);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    bits(16'b101, 3, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    bits(16'b1, 1, 1'b0);
    idle(1);
    drain("midrst", 0, 0, 0);
    for (int i = 0; i < 3; i++) chk("midrst_fill", i, {5'b0, fill[i]}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_det_n.md
SEQ_DET_N -- requirements
Module: seq_det_n

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 4, meaning pattern length in bits (legal 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1011 (PAT_LEN bits), meaning target sequence; MSB is the first bit received.
REQ-003 The block SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping detection, 0 = non-overlapping.
REQ-004 The block SHALL have parameter CNT_W, default 8, meaning match-counter width (legal 1..32).
REQ-005 The block SHALL have port n_clk  input  1  clock; all state updates on the falling edge of n_clk.
REQ-006 The block SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-007 The block SHALL have port en  input  1  serial-bit qualifier; a is sampled only when en=1.
REQ-008 The block SHALL have port a  input  1  serial data bit.
REQ-009 The block SHALL have port clr_cnt  input  1  synchronous match-counter clear.
REQ-010 The block SHALL have port s  output  1  match pulse, registered.
REQ-011 The block SHALL have port t  output  1  window-full flag (fill == PAT_LEN), registered.
REQ-012 The block SHALL have port fill  output  $clog2(PAT_LEN+1)  count of valid bits in the window.
REQ-013 The block SHALL have port cnt  output  CNT_W  number of matches since reset/clear.

Function
REQ-014 On each edge with en=1, the window SHALL shift left and take a into bit 0; fill SHALL increment, saturating at PAT_LEN.
REQ-015 On each edge with en=1, s SHALL become 1 iff the next fill equals PAT_LEN and the next window equals PATTERN; s SHALL otherwise become 0 (one-cycle pulse, latency one edge after the completing bit).
REQ-016 On each edge with en=0, the window, fill and cnt SHALL hold, and s SHALL become 0.
REQ-017 With OVERLAP=1, fill SHALL remain PAT_LEN after a match, so a suffix of one match may begin the next.
REQ-018 With OVERLAP=0, fill SHALL become 0 on the edge that produces a match; bits of the matched sequence SHALL NOT contribute to any later match.
REQ-019 t SHALL equal (fill == PAT_LEN) as a registered value; with OVERLAP=0, t SHALL be 0 in the cycle in which s=1.
REQ-020 cnt SHALL increment by 1 on each edge producing s=1, saturating at 2^CNT_W-1 with no wrap.
REQ-021 clr_cnt=1 SHALL set cnt to 0 on that edge, taking priority over a simultaneous match increment; the match pulse s SHALL still be produced.
REQ-022 clr_cnt SHALL act regardless of en.

Reset
REQ-023 rst=1 at an edge SHALL set s=0, t=0, fill=0, cnt=0 and clear the window, with priority over en, a and clr_cnt.
REQ-024 Assertion of rst mid-pattern SHALL discard all partial bits; detection restarts from an empty window after rst deasserts.

Configuration
REQ-025 With macro SEQ_DET_CNT_EN defined, the match counter and clr_cnt behaviour (REQ-020..022) SHALL be implemented.
REQ-026 Without SEQ_DET_CNT_EN, cnt SHALL be tied to 0, clr_cnt SHALL be ignored, no counter flops SHALL be inferred, and all other behaviour SHALL be unchanged.

Verification
REQ-027 Reset check: hold rst=1 for 2 edges with a=1, en=1 -> s=0, t=0, fill=0, cnt=0.
REQ-028 Basic match (defaults): en=1, a=1,0,1,1 -> s=1 for exactly one cycle after the 4th bit, t=1, cnt=1.
REQ-029 Overlap mode: a=1,0,1,1,0,1,1 -> with OVERLAP=1, two s pulses (after bits 4 and 7), cnt=2; with OVERLAP=0, one pulse, cnt=1, fill=3 at end.
REQ-030 Enable gating: a=1,0, then en=0 with a=1 for 3 edges, then en=1, a=1,1 -> exactly one s pulse, on the final bit; fill held at 2 during the en=0 cycles.
REQ-031 Saturation/clear (CNT_W=2, SEQ_DET_CNT_EN defined): 5 matches -> cnt=3; clr_cnt=1 coincident with a 6th match -> cnt=0, s=1.
REQ-032 Reset mid-pattern: a=1,0,1, then rst=1 for one edge, then a=1 -> no s pulse, fill=1.
